counter_run_ctrl: RTL and testbench



---
 rtl/counter_run_ctrl_if.sv | 26 ++
 rtl/counter_run_ctrl.sv | 132 +++++++++++++
 tb/tb_counter_run_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_run_ctrl_if.sv
// Request/grant bundle between counting requesters and counter_run_ctrl.
// Latency: n/a (wires only). Backpressure: requesters hold req until their done pulse.
// Master drives requests, limits and hold; slave returns grant, status and done.
interface counter_run_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req;
  logic [WIDTH-1:0] lim0;
  logic [WIDTH-1:0] lim1;
  logic             hold;
  logic [1:0]       gnt;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic [1:0]       done;

  modport master (
    output req, lim0, lim1, hold,
    input  gnt, busy, count, tc, done
  );

  modport slave (
    input  req, lim0, lim1, hold,
    output gnt, busy, count, tc, done
  );
endinterface

// File: rtl/counter_run_ctrl.sv
// Run controller + 2-way round-robin arbiter; counts 0..limit of the granted requester.
// Latency: grant 1 edge after req, done L+2 edges (L*PRESCALE+2 with COUNTER_RUN_CTRL_PRESCALE_EN).
// Backpressure: hold freezes the run (count, prescaler and terminal exit); all outputs registered.
module counter_run_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic               clk,
  input  logic               reset,
  counter_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_lim;
  logic [WIDTH-1:0] w_lim_nxt;
  logic [1:0]       r_gnt;
  logic [1:0]       w_gnt_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             r_tc;
  logic             r_busy;
  logic [1:0]       r_done;
  logic             w_win;
  logic             w_tick;

  // Winner index: under contention the requester not granted last time.
  assign w_win = (bus.req == 2'b11) ? ~r_last : bus.req[1];

`ifdef COUNTER_RUN_CTRL_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;

  assign w_tick = (r_pre == PRE_MAX);

  // Held at zero outside RUN, so every run starts with a fresh prescale period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
    end else if (r_state != S_RUN) begin
      r_pre <= '0;
    end else if (!bus.hold) begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
    end
  end
`else
  logic w_unused_prescale;

  assign w_unused_prescale = ^PRESCALE;
  assign w_tick            = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_lim_nxt   = r_lim;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        w_count_nxt = '0;
        w_gnt_nxt   = 2'b00;
        if (|bus.req) begin
          w_state_nxt = S_RUN;
          w_lim_nxt   = w_win ? bus.lim1 : bus.lim0;
          w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
          w_last_nxt  = w_win;
        end
      end
      S_RUN: begin
        // Terminal compare wins over the tick, so the count never passes the limit.
        if (!bus.hold) begin
          if (r_count == r_lim) begin
            w_state_nxt = S_DONE;
          end else if (w_tick) begin
            w_count_nxt = r_count + WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
        w_gnt_nxt   = 2'b00;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
        w_gnt_nxt   = 2'b00;
      end
    endcase
  end

  // Status flags are computed from next-state values so they are flops, not decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_lim   <= '0;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_tc    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_lim   <= w_lim_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_tc    <= (w_state_nxt == S_RUN) && (w_count_nxt == w_lim_nxt);
      r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DONE);
      r_done  <= (w_state_nxt == S_DONE) ? w_gnt_nxt : 2'b00;
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.busy  = r_busy;
  assign bus.count = r_count;
  assign bus.tc    = r_tc;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Scoreboard bench for counter_run_ctrl: expected done/latency pushed at request time, popped at done.
// Expectations scale with PS so the same bench covers the prescaled build.
module tb_counter_run_ctrl;

`ifdef COUNTER_RUN_CTRL_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  counter_run_ctrl_if #(.WIDTH(8)) bus ();

  counter_run_ctrl #(.WIDTH(8), .PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] done;
    int         edges;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns edges elapsed until done is seen; d stays 0 if the budget expires.
  task automatic wait_done(input int budget, output logic [1:0] d, output int edges);
    d     = 2'b00;
    edges = 0;
    while (edges < budget) begin
      tick();
      edges++;
      if (bus.done != 2'b00) begin
        d = bus.done;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus.req  = 2'b00;
    bus.lim0 = 8'd0;
    bus.lim1 = 8'd0;
    bus.hold = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus.gnt, bus.busy, bus.count, bus.tc, bus.done} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b busy=%b count=%0d tc=%b done=%b, expected all zero",
               bus.gnt, bus.busy, bus.count, bus.tc, bus.done);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if ({bus.gnt, bus.busy, bus.done} !== 5'd0) begin
      n_fail++;
      $display("FAIL idle_no_req: got gnt=%b busy=%b done=%b, expected zeros", bus.gnt, bus.busy, bus.done);
    end
  endtask

  task automatic test_single();
    logic [1:0] d;
    int         e;
    int         total;
    exp_t       x;
    bus.lim0 = 8'd3;
    bus.req  = 2'b01;
    sb.push_back('{2'b01, 3 * PS + 2});
    for (int j = 1; j <= 3 * PS + 1; j++) begin
      tick();
      if (j == 1) begin
        n_checks++;
        if (bus.gnt !== 2'b01 || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL single_grant: got gnt=%b busy=%b, expected gnt=01 busy=1", bus.gnt, bus.busy);
        end
      end
      n_checks++;
      if (bus.count !== 8'((j - 1) / PS) || bus.tc !== (((j - 1) / PS) == 3)) begin
        n_fail++;
        $display("FAIL single_count_c%0d: got count=%0d tc=%b, expected count=%0d tc=%b",
                 j, bus.count, bus.tc, (j - 1) / PS, ((j - 1) / PS) == 3);
      end
    end
    wait_done(10, d, e);
    bus.req = 2'b00;
    total   = 3 * PS + 1 + e;
    x       = sb.pop_front();
    n_checks++;
    if (d !== x.done || total !== x.edges) begin
      n_fail++;
      $display("FAIL single_done: got done=%b at edge %0d, expected done=%b at edge %0d", d, total, x.done, x.edges);
    end
    n_checks++;
    if (bus.gnt !== 2'b01 || bus.count !== 8'd3 || bus.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_hold: got gnt=%b count=%0d tc=%b, expected gnt=01 count=3 tc=0",
               bus.gnt, bus.count, bus.tc);
    end
    tick();
    n_checks++;
    if ({bus.gnt, bus.busy, bus.count, bus.done} !== 13'd0) begin
      n_fail++;
      $display("FAIL single_back_idle: got gnt=%b busy=%b count=%0d done=%b, expected zeros",
               bus.gnt, bus.busy, bus.count, bus.done);
    end
  endtask

  task automatic test_contention();
    logic [1:0] d;
    int         e;
    exp_t       x;
    reset    = 1'b1;
    bus.req  = 2'b11;
    bus.lim0 = 8'd2;
    bus.lim1 = 8'd1;
    tick();
    tick();
    reset = 1'b0;
    sb.push_back('{2'b01, 2 * PS + 2});
    sb.push_back('{2'b10, PS + 2});
    sb.push_back('{2'b01, 2 * PS + 2});
    for (int r = 0; r < 3; r++) begin
      wait_done(30, d, e);
      x = sb.pop_front();
      n_checks++;
      if (d !== x.done || e !== x.edges) begin
        n_fail++;
        $display("FAIL contention_run%0d: got done=%b after %0d edges, expected done=%b after %0d edges",
                 r, d, e, x.done, x.edges);
      end
      if (r < 2) begin
        tick();
        n_checks++;
        if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL contention_gap%0d: got gnt=%b busy=%b, expected gnt=00 busy=0", r, bus.gnt, bus.busy);
        end
      end
    end
    bus.req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_zero_limit();
    logic [1:0] d;
    int         e;
    exp_t       x;
    bus.lim1 = 8'd0;
    bus.req  = 2'b10;
    sb.push_back('{2'b10, 2});
    tick();
    n_checks++;
    if (bus.gnt !== 2'b10 || bus.tc !== 1'b1 || bus.count !== 8'd0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_first_run: got gnt=%b tc=%b count=%0d busy=%b, expected gnt=10 tc=1 count=0 busy=1",
               bus.gnt, bus.tc, bus.count, bus.busy);
    end
    wait_done(10, d, e);
    bus.req = 2'b00;
    x       = sb.pop_front();
    n_checks++;
    if (d !== x.done || 1 + e !== x.edges) begin
      n_fail++;
      $display("FAIL zero_done: got done=%b at edge %0d, expected done=%b at edge %0d", d, 1 + e, x.done, x.edges);
    end
    tick();
    tick();
  endtask

  task automatic test_hold();
    logic [1:0] d;
    int         e;
    exp_t       x;
    bus.lim0 = 8'd4;
    bus.req  = 2'b01;
    sb.push_back('{2'b01, 4 * PS + 2 + 3});
    tick();
    tick();
    bus.hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      tick();
      n_checks++;
      if (bus.count !== 8'(1 / PS) || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_frozen_%0d: got count=%0d busy=%b, expected count=%0d busy=1",
                 h, bus.count, bus.busy, 1 / PS);
      end
    end
    bus.hold = 1'b0;
    wait_done(4 * PS + 10, d, e);
    bus.req = 2'b00;
    x       = sb.pop_front();
    n_checks++;
    if (d !== x.done || 5 + e !== x.edges) begin
      n_fail++;
      $display("FAIL hold_done: got done=%b at edge %0d, expected done=%b at edge %0d", d, 5 + e, x.done, x.edges);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    bit found;
    found    = 1'b0;
    bus.lim0 = 8'd200;
    bus.req  = 2'b01;
    tick();
    for (int i = 0; i < 50 * PS + 20; i++) begin
      if (bus.count == 8'd50) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reach50: got count=%0d, expected to reach 50", bus.count);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({bus.gnt, bus.busy, bus.count, bus.tc, bus.done} !== 14'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got gnt=%b busy=%b count=%0d tc=%b done=%b, expected all zero",
               bus.gnt, bus.busy, bus.count, bus.tc, bus.done);
    end
    reset   = 1'b0;
    bus.req = 2'b11;
    tick();
    n_checks++;
    if (bus.gnt !== 2'b01 || bus.done !== 2'b00) begin
      n_fail++;
      $display("FAIL midrun_regrant: got gnt=%b done=%b, expected gnt=01 done=00", bus.gnt, bus.done);
    end
    bus.req = 2'b00;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_prescale();
    logic [1:0] d;
    int         e;
    exp_t       x;
    bus.lim0 = 8'd2;
    bus.req  = 2'b01;
    sb.push_back('{2'b01, 2 * PS + 2});
    for (int j = 1; j <= 2 * PS + 1; j++) begin
      tick();
      n_checks++;
      if (bus.count !== 8'((j - 1) / PS)) begin
        n_fail++;
        $display("FAIL prescale_count_c%0d: got %0d, expected %0d", j, bus.count, (j - 1) / PS);
      end
    end
    wait_done(10, d, e);
    bus.req = 2'b00;
    x       = sb.pop_front();
    n_checks++;
    if (d !== x.done || 2 * PS + 1 + e !== x.edges) begin
      n_fail++;
      $display("FAIL prescale_done: got done=%b at edge %0d, expected done=%b at edge %0d",
               d, 2 * PS + 1 + e, x.done, x.edges);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_zero_limit();
    test_hold();
    test_reset_midrun();
    test_prescale();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected tests to complete");
    $fatal(1, "watchdog");
  end

endmodule
